uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 transmitter. It serialises one character per ready/valid transfer, LSB first. Character length, parity and stop-bit count are set per build. Bit timing comes from an internal divider programmed through the baud_div port, not from an external strobe. It sits between a host-side byte source (FIFO or CSR) and the pad driver.

Parameters:
DATA_BITS, 8, character length in bits; legal range 5..9.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop-bit count; legal values 1 or 2.
DIV_WIDTH, 16, width of the baud divider.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
baud_div  in  DIV_WIDTH  clk cycles per bit; value 0 is treated as 1
s_valid  in  1  character available on s_data
s_data  in  DATA_BITS  character to send
s_ready  out  1  block can accept a character this cycle
tx_serial  out  1  serial line; idles high
busy  out  1  frame in progress
tx_done  out  1  one-cycle pulse when the final stop bit completes

Behaviour:
- Reset values: tx_serial=1, s_ready=1, busy=0, tx_done=0, state=IDLE, all counters 0.
- Reset asserted mid-frame: tx_serial returns high immediately (asynchronous). The in-flight character is dropped. No tx_done pulse.
- Handshake:
  - s_ready = (state==IDLE).
  - A transfer occurs on a rising clk edge with s_valid & s_ready.
  - On transfer, s_data and effective baud_div are latched. Later changes to either have no effect on the current frame.
  - s_valid without s_ready: the character is not consumed. The source holds it.
- State machine: IDLE -> START -> DATA -> PARITY (only if PARITY_MODE!=0) -> STOP -> IDLE.
- Bit timing:
  - On a transfer, the next state is START and tx_serial=0 from the following cycle.
  - Each bit holds tx_serial for exactly D = max(baud_div,1) clk cycles.
  - The bit counter counts D-1 down to 0. The state advances when the count reaches 0.
- DATA: sends bit 0 first. A bit index counts 0..DATA_BITS-1.
- PARITY:
  - Even mode: XOR-reduce of the latched data.
  - Odd mode: inverted XOR-reduce.
  - Parity is computed at latch time.
- STOP:
  - Line high for STOP_BITS*D cycles.
  - In the last cycle of STOP, tx_done=1 and the next state is IDLE.
  - s_ready rises the cycle after tx_done. The line therefore idles high for at least 1 clk between back-to-back frames.
- busy=1 from the cycle after a transfer through the tx_done cycle inclusive.
- Frame length: (1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS)*D cycles, from the first start-bit cycle to the tx_done cycle inclusive.
- Illegal parameter values fail at elaboration (generate-time check). There is no runtime handling of illegal values.
- tx_serial is a registered output with no combinational path from inputs.

Decomposition:
- Shared package uart_pkg holds:
  - Parity-mode constants PAR_NONE/PAR_EVEN/PAR_ODD.
  - State enum uart_tx_state_t (IDLE, START, DATA, PARITY, STOP).
  - Helper function frame_bits(data_bits, parity_mode, stop_bits).
- One sub-module, uart_baud_tick:
  - Loadable down-counter of width DIV_WIDTH.
  - Inputs: load, div.
  - Output: tick, asserted in the last cycle of each bit period.
  - It will be reused by the receiver.

Test Plan:
- Default build (8, none, 1), baud_div=4, send 0xA5 -> tx_serial = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. tx_done pulses at cycle 40 after the first start-bit cycle. busy is high 40 cycles.
- PARITY_MODE=1 (even), 7 data bits, baud_div=2, send 0x07 -> three 1s give parity bit 1. Frame is 1+7+1+1 = 10 bits = 20 cycles.
- PARITY_MODE=2 (odd), STOP_BITS=2, send 0x00 -> parity bit 1, then line high for 2*D cycles before tx_done.
- Back-to-back: s_valid held high with 0x55 then 0x3C -> second transfer occurs the cycle after tx_done. Exactly 1 idle-high clk between frames. s_ready is low throughout each frame.
- baud_div=0 -> behaves as D=1: 10-cycle 8N1 frame. Changing baud_div to 8 mid-frame does not alter the current frame's bit width.
- Reset asserted during DATA bit 3 -> tx_serial=1 in the same cycle, s_ready=1, no tx_done. The next transfer produces a clean full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode codes, transmitter state encoding and
// a frame-length helper used by both the transmitter and its test collateral.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    // Number of bit periods in one frame, start bit through last stop bit.
    function automatic int unsigned frame_bits(input int unsigned data_bits,
                                               input int unsigned parity_mode,
                                               input int unsigned stop_bits);
        return 1 + data_bits + ((parity_mode != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable bit-period down-counter; tick marks the last clk of each bit period.
// The period is captured on load, so later divider changes do not disturb a frame.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_o,
    output logic                 tick_next_c_o
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] period_q, period_d;
    logic [DIV_WIDTH-1:0] div_eff;
    logic                 tick_q, tick_d;

    // Count D-1 down to 0 and auto-reload for the next bit while enabled.
    always_comb begin
        div_eff  = (div_i == '0) ? DIV_WIDTH'(1) : div_i;
        cnt_d    = cnt_q;
        period_d = period_q;
        if (load_i) begin
            period_d = div_eff - DIV_WIDTH'(1);
            cnt_d    = div_eff - DIV_WIDTH'(1);
        end else if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q == '0) begin
            cnt_d = period_q;
        end else begin
            cnt_d = cnt_q - DIV_WIDTH'(1);
        end
        tick_d = (load_i || en_i) && (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            period_q <= '0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            tick_q   <= tick_d;
        end
    end

    assign tick_o        = tick_q;
    assign tick_next_c_o = tick_d;

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: one character per ready/valid transfer, LSB
// first, optional parity, 1 or 2 stop bits, bit time from an internal divider.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned DIV_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 s_valid,
    input  logic [DATA_BITS-1:0] s_data,
    output logic                 s_ready,
    output logic                 tx_serial,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be in 5..9");
    end
    if (PARITY_MODE > PAR_ODD) begin : g_bad_parity_mode
        $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (DIV_WIDTH < 1) begin : g_bad_div_width
        $error("uart_tx_frame: DIV_WIDTH must be at least 1");
    end

    uart_tx_state_t       state_q, state_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 load_c;
    logic                 en_c;
    logic                 tick;
    logic                 tick_next;

    uart_baud_tick #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_baud_tick (
        .clk          (clk),
        .reset        (reset),
        .load_i       (load_c),
        .en_i         (en_c),
        .div_i        (baud_div),
        .tick_o       (tick),
        .tick_next_c_o(tick_next)
    );

    // Next state, captured frame contents and the line value for the next cycle.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        data_d     = data_q;
        par_d      = par_q;
        load_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    state_d = START;
                    data_d  = s_data;
                    load_c  = 1'b1;
                    if (PARITY_MODE == PAR_ODD) begin
                        par_d = ~(^s_data);
                    end else begin
                        par_d = ^s_data;
                    end
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d    = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[bit_idx_d];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    assign en_c = (state_d != IDLE);

    // tx_done is registered, so it is predicted one cycle ahead from the counter.
    assign done_d = (state_d == STOP) && (stop_idx_d == 1'(STOP_BITS - 1)) && tick_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            data_q     <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            data_q     <= data_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_serial = tx_q;
    assign s_ready   = ready_q;
    assign busy      = busy_q;
    assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three builds (8N1, 7E1, 8O2) checked every cycle
// against a frame-arithmetic model, plus directed vectors and corner sequences.
module tb_uart_tx_frame;

    localparam int NB [3] = '{8, 7, 8};
    localparam int PM [3] = '{0, 1, 2};
    localparam int SB [3] = '{1, 1, 2};

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       v = '0;
    logic [2:0][15:0] dv = '0;
    logic [2:0][8:0]  dat = '0;
    logic [2:0]       rdy, tx, bsy, done;
    logic             chk_on = 1'b0;

    int tests = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .DIV_WIDTH(16)) dut0 (
        .clk(clk), .reset(reset), .baud_div(dv[0]), .s_valid(v[0]), .s_data(dat[0][7:0]),
        .s_ready(rdy[0]), .tx_serial(tx[0]), .busy(bsy[0]), .tx_done(done[0]));

    uart_tx_frame #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1), .DIV_WIDTH(16)) dut1 (
        .clk(clk), .reset(reset), .baud_div(dv[1]), .s_valid(v[1]), .s_data(dat[1][6:0]),
        .s_ready(rdy[1]), .tx_serial(tx[1]), .busy(bsy[1]), .tx_done(done[1]));

    uart_tx_frame #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2), .DIV_WIDTH(16)) dut2 (
        .clk(clk), .reset(reset), .baud_div(dv[2]), .s_valid(v[2]), .s_data(dat[2][7:0]),
        .s_ready(rdy[2]), .tx_serial(tx[2]), .busy(bsy[2]), .tx_done(done[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 1 : int'(d);
    endfunction

    function automatic int frame_len(input int i, input int d);
        return (1 + NB[i] + ((PM[i] != 0) ? 1 : 0) + SB[i]) * d;
    endfunction

    // Line level in frame cycle cyc: start, data LSB first, parity, stop bits.
    function automatic int exp_line(input int data, input int i, input int d, input int cyc);
        int b;
        int ones;
        b = cyc / d;
        ones = $countones(data);
        if (b == 0) return 0;
        if (b <= NB[i]) return (data >> (b - 1)) & 1;
        if (PM[i] != 0 && b == NB[i] + 1) return (PM[i] == 1) ? (ones & 1) : 1 - (ones & 1);
        return 1;
    endfunction

    // Reference model: -1 when idle, otherwise the index of the current frame cycle.
    int m_cyc [3] = '{-1, -1, -1};
    int m_len [3];
    int m_d [3];
    int m_data [3];

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                m_cyc[i] <= -1;
            end else if (m_cyc[i] >= 0) begin
                m_cyc[i] <= (m_cyc[i] + 1 == m_len[i]) ? -1 : m_cyc[i] + 1;
            end else if (v[i]) begin
                m_cyc[i]  <= 0;
                m_data[i] <= int'(dat[i]) & ((1 << NB[i]) - 1);
                m_d[i]    <= eff_div(dv[i]);
                m_len[i]  <= frame_len(i, eff_div(dv[i]));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && chk_on) begin
            for (int i = 0; i < 3; i++) begin
                if (m_cyc[i] < 0) begin
                    check($sformatf("dut%0d_tx_idle", i), 32'(tx[i]), 32'd1);
                    check($sformatf("dut%0d_ready_idle", i), 32'(rdy[i]), 32'd1);
                    check($sformatf("dut%0d_busy_idle", i), 32'(bsy[i]), 32'd0);
                    check($sformatf("dut%0d_done_idle", i), 32'(done[i]), 32'd0);
                end else begin
                    check($sformatf("dut%0d_tx_cyc%0d", i, m_cyc[i]), 32'(tx[i]),
                          32'(exp_line(m_data[i], i, m_d[i], m_cyc[i])));
                    check($sformatf("dut%0d_ready_frame", i), 32'(rdy[i]), 32'd0);
                    check($sformatf("dut%0d_busy_frame", i), 32'(bsy[i]), 32'd1);
                    check($sformatf("dut%0d_done_cyc%0d", i, m_cyc[i]), 32'(done[i]),
                          32'(m_cyc[i] == m_len[i] - 1));
                end
            end
        end
    end

    // Send one character to an idle DUT; capture the first cycle of each bit and the frame length.
    task automatic run_vec(input int sel, input int div, input int data,
                           output logic [15:0] line, output int len);
        int d;
        d = (div == 0) ? 1 : div;
        line = '0;
        len = -1;
        @(negedge clk);
        dv[sel] = 16'(div);
        dat[sel] = 9'(data);
        v[sel] = 1'b1;
        @(negedge clk);
        v[sel] = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (k % d == 0 && k / d < 16) line[k / d] = tx[sel];
            if (done[sel]) begin
                len = k + 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    typedef struct {
        int          sel;
        int          div;
        int          data;
        int          nbits;
        logic [15:0] line;
        int          len;
    } vec_t;

    vec_t vt [8];

    initial begin
        logic [15:0] line;
        int          len;
        int          k;
        int          seen;

        vt[0] = '{0, 4, 'hA5, 10, 16'h034A, 40};
        vt[1] = '{0, 1, 'hFF, 10, 16'h03FE, 10};
        vt[2] = '{0, 0, 'h00, 10, 16'h0200, 10};
        vt[3] = '{0, 3, 'h3C, 10, 16'h0278, 30};
        vt[4] = '{1, 2, 'h07, 10, 16'h030E, 20};
        vt[5] = '{1, 2, 'h55, 10, 16'h02AA, 20};
        vt[6] = '{2, 3, 'h00, 12, 16'h0E00, 36};
        vt[7] = '{2, 1, 'h01, 12, 16'h0C02, 12};

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_tx%0d", i), 32'(tx[i]), 32'd1);
            check($sformatf("reset_ready%0d", i), 32'(rdy[i]), 32'd1);
            check($sformatf("reset_busy%0d", i), 32'(bsy[i]), 32'd0);
            check($sformatf("reset_done%0d", i), 32'(done[i]), 32'd0);
        end
        #2 reset = 1'b0;
        chk_on = 1'b1;

        for (int t = 0; t < 8; t++) begin
            run_vec(vt[t].sel, vt[t].div, vt[t].data, line, len);
            check($sformatf("vec%0d_line", t), 32'(line & 16'((1 << vt[t].nbits) - 1)),
                  32'(vt[t].line));
            check($sformatf("vec%0d_len", t), 32'(len), 32'(vt[t].len));
        end

        // Back-to-back frames with s_valid held high.
        @(negedge clk);
        dv[0] = 16'd2;
        dat[0] = 9'h055;
        v[0] = 1'b1;
        @(negedge clk);
        check("b2b_ready_low", 32'(rdy[0]), 32'd0);
        dat[0] = 9'h03C;
        k = 0;
        while (!done[0] && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("b2b_len1", 32'(k + 1), 32'd20);
        @(negedge clk);
        check("b2b_gap_ready", 32'(rdy[0]), 32'd1);
        check("b2b_gap_tx", 32'(tx[0]), 32'd1);
        check("b2b_gap_busy", 32'(bsy[0]), 32'd0);
        @(negedge clk);
        check("b2b_start2_tx", 32'(tx[0]), 32'd0);
        check("b2b_start2_ready", 32'(rdy[0]), 32'd0);
        v[0] = 1'b0;
        k = 0;
        while (!done[0] && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("b2b_len2", 32'(k + 1), 32'd20);
        @(negedge clk);

        // baud_div of 0 acts as 1 and a mid-frame change is ignored.
        dv[0] = 16'd0;
        dat[0] = 9'h096;
        v[0] = 1'b1;
        @(negedge clk);
        v[0] = 1'b0;
        dv[0] = 16'd8;
        k = 0;
        while (!done[0] && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("div0_len", 32'(k + 1), 32'd10);
        @(negedge clk);

        // Reset during data bit 3: line returns high at once and no tx_done follows.
        dv[0] = 16'd4;
        dat[0] = 9'h000;
        v[0] = 1'b1;
        @(negedge clk);
        v[0] = 1'b0;
        repeat (17) @(negedge clk);
        check("rst_pre_tx", 32'(tx[0]), 32'd0);
        check("rst_pre_busy", 32'(bsy[0]), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_tx", 32'(tx[0]), 32'd1);
        check("rst_ready", 32'(rdy[0]), 32'd1);
        check("rst_busy", 32'(bsy[0]), 32'd0);
        check("rst_done", 32'(done[0]), 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (done[0]) seen++;
        end
        check("rst_no_done", 32'(seen), 32'd0);
        run_vec(0, 4, 'hA5, line, len);
        check("rst_after_line", 32'(line & 16'h03FF), 32'h034A);
        check("rst_after_len", 32'(len), 32'd40);

        // Random traffic on all builds; data and divider churn every cycle.
        repeat (2000) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                v[i] = ($urandom_range(0, 3) != 0);
                dat[i] = 9'($urandom);
                dv[i] = 16'($urandom_range(0, 4));
            end
        end
        @(negedge clk);
        v = '0;
        repeat (120) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
